// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART-style serial receiver producing parallel words
// Mid-bit sampling FSM; good frames strobe wr_en, bad stop bits strobe frame_err.
module uart_rx_deserializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [WIDTH-1:0] out,
  output logic             wr_en,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state;
  logic             rx_m;
  logic             rx_s;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             stop_done;
  logic             stop_ok;

  // Strobes, out and busy trail the FSM by one cycle so busy falls with wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      stop_done <= 1'b0;
      stop_ok   <= 1'b0;
      out       <= '0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      busy      <= (state != IDLE);
      wr_en     <= stop_done & stop_ok;
      frame_err <= stop_done & ~stop_ok;
      if (stop_done && stop_ok) out <= shreg;
      stop_done <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            shreg   <= (shreg >> 1) | (WIDTH'(rx_s) << (WIDTH - 1));
            bit_idx <= bit_idx + 1'b1;
            cnt     <= '0;
            if (bit_idx == LAST_BIT) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            stop_done <= 1'b1;
            stop_ok   <= rx_s;
            cnt       <= '0;
            state     <= rx_s ? IDLE : BRK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
